// File: rtl/mac_unit.sv
// ---------------------------------------------------------------------------
// mac_unit
//   Signed multiply-accumulate element for the systolic array. On every rising
//   clk edge with en=1 the full-precision product a*b is added into a running
//   accumulator. acc_out is read directly from the accumulator register.
//
// Parameters
//   WIDTH     signed operand width of a and b
//   ACC       signed accumulator width (must be >= 2*WIDTH)
//   SATURATE  0 = wrap modulo 2^ACC on overflow, 1 = clamp to ACC limits
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous reset, active HIGH despite the name
//   en       accumulate enable, sampled on rising clk
//   a, b     signed operands, sampled only on enabled edges
//   acc_out  signed accumulator value (registered)
// ---------------------------------------------------------------------------
module mac_unit #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned ACC      = 32,
    parameter bit          SATURATE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic signed [WIDTH-1:0]  a,
    input  logic signed [WIDTH-1:0]  b,
    output logic signed [ACC-1:0]    acc_out
);

    localparam int unsigned PW = 2 * WIDTH;

    // Reject accumulators too narrow to hold a single full product.
    generate
        if (ACC < PW) begin : g_acc_too_narrow
            $error("mac_unit: ACC must be >= 2*WIDTH");
        end
    endgenerate

    localparam logic signed [ACC-1:0] ACC_MAX = {1'b0, {(ACC-1){1'b1}}};
    localparam logic signed [ACC-1:0] ACC_MIN = {1'b1, {(ACC-1){1'b0}}};

    logic signed [ACC-1:0] acc_q;
    logic signed [PW-1:0]  prod_c;
    logic signed [ACC-1:0] prod_ext_c;
    logic signed [ACC-1:0] sum_c;
    logic                  ovf_c;
    logic signed [ACC-1:0] acc_d_c;

    // Full-precision signed product; -2^(W-1) squared fits exactly in 2W bits.
    always_comb begin
        prod_c = PW'(a) * PW'(b);
    end

    // Sign-extend product to accumulator width and add (wraps modulo 2^ACC).
    always_comb begin
        prod_ext_c = ACC'(prod_c);
        sum_c      = acc_q + prod_ext_c;
    end

    // Overflow only when both addends share a sign that the sum does not.
    always_comb begin
        ovf_c = (acc_q[ACC-1] == prod_ext_c[ACC-1]) &&
                (sum_c[ACC-1] != acc_q[ACC-1]);
    end

    // Next accumulator value: wrap or clamp toward the addends' sign.
    always_comb begin
        acc_d_c = sum_c;
        if (SATURATE && ovf_c) begin
            acc_d_c = acc_q[ACC-1] ? ACC_MIN : ACC_MAX;
        end
    end

    // Accumulator register; reset is asynchronous and active-high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= acc_d_c;
        end
    end

    assign acc_out = acc_q;

endmodule

// File: tb/tb_mac_unit.sv
module tb_mac_unit;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic signed [31:0] acc32;
    logic signed [15:0] acc16w;
    logic signed [15:0] acc16s;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mac_unit #(.WIDTH(8), .ACC(32), .SATURATE(1'b0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .acc_out(acc32));

    mac_unit #(.WIDTH(8), .ACC(16), .SATURATE(1'b0)) u_dut16w (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .acc_out(acc16w));

    mac_unit #(.WIDTH(8), .ACC(16), .SATURATE(1'b1)) u_dut16s (
        .clk(clk), .rst_n(rst_n), .en(en), .a(a), .b(b), .acc_out(acc16s));

    // Drive inputs on the falling edge, then sample 1 time unit after rising edge.
    task automatic step(input logic e, input int av, input int bv);
        @(negedge clk);
        en = e;
        a  = 8'(av);
        b  = 8'(bv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en    = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b1;
        en = 1'b0; a = 8'sd0; b = 8'sd0;
        #1;
        total++;
        if (acc32 !== 32'sd0) begin
            bad++; $display("FAIL reset_async_assert acc=%0d want=0", acc32);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            total++;
            if (acc32 !== 32'sd0) begin
                bad++; $display("FAIL reset_hold[%0d] acc=%0d want=0", i, acc32);
            end
        end
        // Edges with en=1 are ignored while reset is held.
        @(negedge clk);
        en = 1'b1; a = 8'sd5; b = 8'sd5;
        @(posedge clk); #1;
        total++;
        if (acc32 !== 32'sd0) begin
            bad++; $display("FAIL reset_ignores_en acc=%0d want=0", acc32);
        end
        // Release, accumulate once, then assert reset mid-cycle.
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b1; a = 8'sd2; b = 8'sd3;
        @(posedge clk); #1;
        total++;
        if (acc32 !== 32'sd6) begin
            bad++; $display("FAIL reset_first_edge acc=%0d want=6", acc32);
        end
        #2;
        rst_n = 1'b1;
        #1;
        total++;
        if (acc32 !== 32'sd0) begin
            bad++; $display("FAIL reset_mid_cycle acc=%0d want=0", acc32);
        end
        @(negedge clk);
        rst_n = 1'b0;
        en = 1'b0;
    endtask

    task automatic test_accumulate();
        int exp_v[4] = '{12, 24, 36, 48};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 3, 4);
            total++;
            if (acc32 !== 32'(exp_v[i])) begin
                bad++; $display("FAIL accumulate[%0d] acc=%0d want=%0d", i, acc32, exp_v[i]);
            end
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 7, 9);
            total++;
            if (acc32 !== 32'sd48) begin
                bad++; $display("FAIL hold[%0d] acc=%0d want=48", i, acc32);
            end
        end
    endtask

    task automatic test_zero_product();
        step(1'b1, 0, 77);
        total++;
        if (acc32 !== 32'sd48) begin
            bad++; $display("FAIL zero_a acc=%0d want=48", acc32);
        end
        step(1'b1, -100, 0);
        total++;
        if (acc32 !== 32'sd48) begin
            bad++; $display("FAIL zero_b acc=%0d want=48", acc32);
        end
    endtask

    task automatic test_signed();
        do_reset();
        step(1'b1, -5, 6);
        total++;
        if (acc32 !== -32'sd30) begin
            bad++; $display("FAIL signed_0 acc=%0d want=-30", acc32);
        end
        step(1'b1, -5, 6);
        total++;
        if (acc32 !== -32'sd60) begin
            bad++; $display("FAIL signed_1 acc=%0d want=-60", acc32);
        end
        step(1'b1, -8, -8);
        total++;
        if (acc32 !== 32'sd4) begin
            bad++; $display("FAIL signed_2 acc=%0d want=4", acc32);
        end
    endtask

    task automatic test_extremes();
        do_reset();
        step(1'b1, -128, -128);
        total++;
        if (acc32 !== 32'sd16384) begin
            bad++; $display("FAIL extreme_negneg acc=%0d want=16384", acc32);
        end
        total++;
        if (acc16w !== 16'sd16384) begin
            bad++; $display("FAIL extreme_negneg_acc16 acc=%0d want=16384", acc16w);
        end
        do_reset();
        step(1'b1, 127, -128);
        total++;
        if (acc32 !== -32'sd16256) begin
            bad++; $display("FAIL extreme_posneg acc=%0d want=-16256", acc32);
        end
    endtask

    // 16129 per edge: 16129, 32258, 48387 (wraps to -17149 / clamps to 32767).
    task automatic test_overflow_pos();
        int exp_w[3] = '{16129, 32258, -17149};
        int exp_s[3] = '{16129, 32258, 32767};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 127, 127);
            total++;
            if (acc16w !== 16'(exp_w[i])) begin
                bad++; $display("FAIL ovf_pos_wrap[%0d] acc=%0d want=%0d", i, acc16w, exp_w[i]);
            end
            total++;
            if (acc16s !== 16'(exp_s[i])) begin
                bad++; $display("FAIL ovf_pos_sat[%0d] acc=%0d want=%0d", i, acc16s, exp_s[i]);
            end
        end
        // Saturated value then drops by a negative product without sticking.
        step(1'b1, -1, 100);
        total++;
        if (acc16s !== 16'sd32667) begin
            bad++; $display("FAIL ovf_pos_sat_recover acc=%0d want=32667", acc16s);
        end
    endtask

    // -16256 per edge: -16256, -32512, -48768 (wraps to 16768 / clamps to -32768).
    task automatic test_overflow_neg();
        int exp_w[3] = '{-16256, -32512, 16768};
        int exp_s[3] = '{-16256, -32512, -32768};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, -128, 127);
            total++;
            if (acc16w !== 16'(exp_w[i])) begin
                bad++; $display("FAIL ovf_neg_wrap[%0d] acc=%0d want=%0d", i, acc16w, exp_w[i]);
            end
            total++;
            if (acc16s !== 16'(exp_s[i])) begin
                bad++; $display("FAIL ovf_neg_sat[%0d] acc=%0d want=%0d", i, acc16s, exp_s[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int av[5]  = '{10, -3, 0, 127, -128};
        int bv[5]  = '{10, 7, 50, 1, 1};
        bit ev[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int exp_v[5] = '{100, 79, 79, 79, -49};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(ev[i], av[i], bv[i]);
            total++;
            if (acc32 !== 32'(exp_v[i])) begin
                bad++; $display("FAIL back_to_back[%0d] acc=%0d want=%0d", i, acc32, exp_v[i]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b1;
        en    = 1'b0;
        a     = 8'sd0;
        b     = 8'sd0;
        test_reset();
        test_accumulate();
        test_hold();
        test_zero_product();
        test_signed();
        test_extremes();
        test_overflow_pos();
        test_overflow_neg();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
